motor_pwm_driver: RTL



---
 rtl/motor_pwm_driver.sv | 267 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/motor_pwm_driver.sv
// motor_pwm_driver / motor_pwm_channel
//
// Turns the two 8-bit motor command words into H-bridge PWM drive. Each word
// is decoded to a direction and a 0..4 drive level. The duty cycle is slewed
// towards the decoded target, and a reversal first ramps the duty to zero and
// then holds both bridge inputs low for a dead-time before the direction flips.
//
// motor_pwm_driver ports:
//   clk          in   system clock, rising edge
//   rst_n        in   synchronous active-low reset
//   right_motor  in   8-bit right motor command word
//   left_motor   in   8-bit left motor command word
//   r_in_a/b     out  right bridge inputs (A = forward PWM, B = reverse PWM)
//   l_in_a/b     out  left bridge inputs
//   fault        out  [1]=right, [0]=left: command word invalid
//   at_target    out  [1]=right, [0]=left: duty settled on target, no reversal
//
// motor_pwm_channel ports:
//   clk, rst_n   as above
//   cmd          raw command word for this motor
//   tick         shared one-cycle ramp pulse
//   cnt          shared PWM period counter
//   in_a, in_b   bridge inputs for this motor
//   fault        registered invalid-word flag
//   at_target    registered settled flag

module motor_pwm_channel #(
   parameter int PWM_PERIOD  = 1000,
   parameter int DUTY_STEP   = 25,
   parameter int DEAD_CYCLES = 100
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  cmd,
   input  logic        tick,
   input  logic [15:0] cnt,
   output logic        in_a,
   output logic        in_b,
   output logic        fault,
   output logic        at_target
);

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      RAMPDN = 2'd1,
      DEAD   = 2'd2
   } state_t;

   localparam logic [15:0] QUARTER = 16'(PWM_PERIOD / 4);
   localparam logic [15:0] STEP = 16'(DUTY_STEP);
   localparam logic [15:0] CNT_LAST = 16'(PWM_PERIOD - 1);
   localparam int DW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
   localparam logic [DW-1:0] DEAD_LAST = DW'(DEAD_CYCLES - 1);

   // Result layout: {invalid, reverse, level[2:0]}. Only thermometer-coded
   // nibbles are legal; an invalid or zero word leaves level 0 and the
   // reverse flag is ignored because level 0 never requests a direction.
   function automatic logic [4:0] decode_word(input logic [7:0] w);
      logic [2:0] lvl;
      logic       rev;
      logic       bad;
      lvl = 3'd0;
      rev = 1'b0;
      bad = 1'b0;
      if (w == 8'h00) begin
         lvl = 3'd0;
      end else if (w[7:4] == 4'h0) begin
         case (w[3:0])
            4'b1000: lvl = 3'd1;
            4'b1100: lvl = 3'd2;
            4'b1110: lvl = 3'd3;
            4'b1111: lvl = 3'd4;
            default: bad = 1'b1;
         endcase
      end else if (w[3:0] == 4'h0) begin
         rev = 1'b1;
         case (w[7:4])
            4'b0001: lvl = 3'd1;
            4'b0011: lvl = 3'd2;
            4'b0111: lvl = 3'd3;
            4'b1111: lvl = 3'd4;
            default: bad = 1'b1;
         endcase
      end else begin
         bad = 1'b1;
      end
      if (bad) begin
         lvl = 3'd0;
         rev = 1'b0;
      end
      return {bad, rev, lvl};
   endfunction

   logic [4:0]    dec_q;
   logic [2:0]    level;
   logic          req_rev;
   logic          opposite;
   logic [15:0]   target;
   logic          wrap;

   state_t        state, state_next;
   logic [15:0]   duty, duty_next, shadow;
   logic          dir, dir_next;
   logic [DW-1:0] dead_cnt, dead_next;
   logic          active;

   assign level    = dec_q[2:0];
   assign req_rev  = dec_q[3];
   assign fault    = dec_q[4];
   assign target   = 16'(level) * QUARTER;
   assign opposite = (level != 3'd0) && (req_rev != dir);
   assign wrap     = (cnt == CNT_LAST);
   assign active   = (cnt < shadow);

   // Next-state and duty slewing. A zero or invalid word carries no
   // direction, so it never counts as a reversal request.
   always_comb begin
      state_next = state;
      duty_next  = duty;
      dir_next   = dir;
      dead_next  = dead_cnt;
      case (state)
         RUN: begin
            if (opposite) begin
               if (duty != 16'd0) begin
                  state_next = RAMPDN;
               end else begin
                  state_next = DEAD;
                  dead_next  = '0;
               end
            end else if (tick) begin
               if (duty < target) begin
                  duty_next = ((target - duty) > STEP) ? duty + STEP : target;
               end else if (duty > target) begin
                  duty_next = ((duty - target) > STEP) ? duty - STEP : target;
               end
            end
         end
         RAMPDN: begin
            if (!opposite) begin
               state_next = RUN;
            end else if (duty == 16'd0) begin
               state_next = DEAD;
               dead_next  = '0;
            end else if (tick) begin
               duty_next = (duty > STEP) ? duty - STEP : 16'd0;
            end
         end
         DEAD: begin
            if (dead_cnt == DEAD_LAST) begin
               state_next = RUN;
               dir_next   = ~dir;
            end else begin
               dead_next = dead_cnt + 1'b1;
            end
         end
         default: begin
            state_next = RUN;
         end
      endcase
   end

   // State, duty and registered bridge outputs. The shadow is loaded on the
   // last count of a period with the pre-update duty, so a ramp step landing
   // on that cycle only shows up one period later. Direction gates which
   // bridge input may be driven, so A and B can never both be high.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dec_q     <= 5'd0;
         state     <= RUN;
         duty      <= 16'd0;
         dir       <= 1'b0;
         dead_cnt  <= '0;
         shadow    <= 16'd0;
         in_a      <= 1'b0;
         in_b      <= 1'b0;
         at_target <= 1'b0;
      end else begin
         dec_q     <= decode_word(cmd);
         state     <= state_next;
         duty      <= duty_next;
         dir       <= dir_next;
         dead_cnt  <= dead_next;
         if (wrap) begin
            shadow <= duty;
         end
         in_a      <= (state != DEAD) && !dir && active;
         in_b      <= (state != DEAD) && dir && active;
         at_target <= (state == RUN) && (duty == target);
      end
   end

endmodule

module motor_pwm_driver #(
   parameter int PWM_PERIOD  = 1000,
   parameter int RAMP_DIV    = 50000,
   parameter int DUTY_STEP   = 25,
   parameter int DEAD_CYCLES = 100
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] right_motor,
   input  logic [7:0] left_motor,
   output logic       r_in_a,
   output logic       r_in_b,
   output logic       l_in_a,
   output logic       l_in_b,
   output logic [1:0] fault,
   output logic [1:0] at_target
);

   localparam int RW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
   localparam logic [RW-1:0] RAMP_LAST = RW'(RAMP_DIV - 1);
   localparam logic [15:0] CNT_LAST = 16'(PWM_PERIOD - 1);

   logic [15:0]   cnt;
   logic [RW-1:0] ramp_cnt;
   logic          tick;

   assign tick = (ramp_cnt == RAMP_LAST);

   // Shared PWM period counter and ramp divider; both motors see the same
   // period boundaries and the same slew ticks.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt      <= 16'd0;
         ramp_cnt <= '0;
      end else begin
         cnt      <= (cnt == CNT_LAST) ? 16'd0 : cnt + 16'd1;
         ramp_cnt <= tick ? '0 : ramp_cnt + 1'b1;
      end
   end

   motor_pwm_channel #(
      .PWM_PERIOD (PWM_PERIOD),
      .DUTY_STEP  (DUTY_STEP),
      .DEAD_CYCLES(DEAD_CYCLES)
   ) u_right (
      .clk      (clk),
      .rst_n    (rst_n),
      .cmd      (right_motor),
      .tick     (tick),
      .cnt      (cnt),
      .in_a     (r_in_a),
      .in_b     (r_in_b),
      .fault    (fault[1]),
      .at_target(at_target[1])
   );

   motor_pwm_channel #(
      .PWM_PERIOD (PWM_PERIOD),
      .DUTY_STEP  (DUTY_STEP),
      .DEAD_CYCLES(DEAD_CYCLES)
   ) u_left (
      .clk      (clk),
      .rst_n    (rst_n),
      .cmd      (left_motor),
      .tick     (tick),
      .cnt      (cnt),
      .in_a     (l_in_a),
      .in_b     (l_in_b),
      .fault    (fault[0]),
      .at_target(at_target[0])
   );

endmodule
